// File: rtl/dds_voice_bank.sv
// Multi-voice DDS engine: NVOICE phase accumulators share one adder, visited one slot per cycle.
// Voice waves are mixed over a frame of NVOICE cycles and emitted as one scaled sample.
module dds_voice_bank #(
  parameter int unsigned NVOICE = 4,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned TUNE_W = 16,
  parameter int unsigned OUT_W  = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ena_i,
  input  logic                      wr_en_i,
  input  logic [$clog2(NVOICE)-1:0] wr_voice_i,
  input  logic [TUNE_W-1:0]         wr_tune_i,
  input  logic [1:0]                wr_mode_i,
  input  logic                      phase_clr_i,
  output logic [OUT_W-1:0]          sample_o,
  output logic                      sample_vld_o
);

  localparam int unsigned SlotW = $clog2(NVOICE);
  localparam int unsigned MixW  = OUT_W + SlotW;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NVOICE - 1);

  logic [ACC_W-1:0]  acc_q  [NVOICE];
  logic [ACC_W-1:0]  acc_d  [NVOICE];
  logic [TUNE_W-1:0] tune_q [NVOICE];
  logic [TUNE_W-1:0] tune_d [NVOICE];
  logic [1:0]        mode_q [NVOICE];
  logic [1:0]        mode_d [NVOICE];
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [MixW-1:0]   mix_q, mix_d;
  logic [OUT_W-1:0]  sample_q, sample_d;
  logic              vld_q, vld_d;

  logic [ACC_W-1:0] cur_acc;
  logic [1:0]       cur_mode;
  logic [OUT_W-1:0] tri_t;
  logic [OUT_W-1:0] wave;
  logic [MixW-1:0]  mix_sum;

  // Waveform of the current slot, taken from the accumulator value before this cycle's add.
  always_comb begin
    cur_acc  = acc_q[slot_q];
    cur_mode = mode_q[slot_q];
    tri_t    = cur_acc[ACC_W-2 -: OUT_W];
    case (cur_mode)
      2'd1:    wave = cur_acc[ACC_W-1 -: OUT_W];
      2'd2:    wave = {OUT_W{cur_acc[ACC_W-1]}};
      2'd3:    wave = cur_acc[ACC_W-1] ? ~tri_t : tri_t;
      default: wave = '0;
    endcase
    mix_sum = mix_q + MixW'(wave);
  end

  always_comb begin
    acc_d    = acc_q;
    tune_d   = tune_q;
    mode_d   = mode_q;
    slot_d   = slot_q;
    mix_d    = mix_q;
    sample_d = sample_q;
    vld_d    = 1'b0;

    if (ena_i) begin
      acc_d[slot_q] = (cur_mode == 2'd0) ? '0 : cur_acc + ACC_W'(tune_q[slot_q]);
      mix_d         = (slot_q == '0) ? MixW'(wave) : mix_sum;
      if (slot_q == LastSlot) begin
        sample_d = mix_sum[MixW-1:SlotW];
        vld_d    = 1'b1;
        slot_d   = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end

    // The slot's add above has already consumed the old tune/mode.
    if (wr_en_i && (int'(wr_voice_i) < int'(NVOICE))) begin
      tune_d[wr_voice_i] = wr_tune_i;
      mode_d[wr_voice_i] = wr_mode_i;
    end

    if (phase_clr_i) begin
      for (int k = 0; k < int'(NVOICE); k++) begin
        acc_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q    <= '{default: '0};
      tune_q   <= '{default: '0};
      mode_q   <= '{default: '0};
      slot_q   <= '0;
      mix_q    <= '0;
      sample_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      tune_q   <= tune_d;
      mode_q   <= mode_d;
      slot_q   <= slot_d;
      mix_q    <= mix_d;
      sample_q <= sample_d;
      vld_q    <= vld_d;
    end
  end

  assign sample_o     = sample_q;
  assign sample_vld_o = vld_q;

endmodule
